// File: rtl/bw_clk_cken_seq.sv
// Cluster clock-enable / global reset sequencer for the cluster clock headers.
// Optional staggered ramp: define BW_CLK_SEQ_STAGGER_EN (default: all clusters at once).
module bw_clk_cken_seq #(
    parameter int NUM_CLUSTERS = 4,
    parameter int RST_HOLD_CYC = 16,
    parameter int STAGGER_CYC  = 4,
    parameter int DBG_HOLD_CYC = 8
) (
    input  logic                    gclk,
    input  logic                    rst,
    input  logic                    pwr_rst_req,
    input  logic                    dbg_req,
    input  logic [NUM_CLUSTERS-1:0] cken_mask,
    output logic [NUM_CLUSTERS-1:0] cluster_cken,
    output logic                    grst_l,
    output logic                    gdbginit_l,
    output logic                    seq_busy,
    output logic                    seq_done
);

    localparam int MAX_A = (RST_HOLD_CYC > STAGGER_CYC) ? RST_HOLD_CYC : STAGGER_CYC;
    localparam int MAX_C = (MAX_A > DBG_HOLD_CYC) ? MAX_A : DBG_HOLD_CYC;
    localparam int CW    = $clog2(MAX_C) + 1;

    localparam logic [CW-1:0] HOLD_N  = CW'(RST_HOLD_CYC);
    localparam logic [CW-1:0] HOLD_M1 = CW'(RST_HOLD_CYC - 1);
    localparam logic [CW-1:0] STAG_M1 = CW'(STAGGER_CYC - 1);
    localparam logic [CW-1:0] DBG_M1  = CW'(DBG_HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_RST_HOLD,
        S_RAMP,
        S_SETTLE,
        S_RUN,
        S_DBG
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_CLUSTERS-1:0] ramp_q, ramp_d;

`ifdef BW_CLK_SEQ_STAGGER_EN
    localparam int SW = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;
    localparam logic [SW-1:0] LAST = SW'(NUM_CLUSTERS - 1);

    logic [SW-1:0] slot_q, slot_d;

    always_ff @(posedge gclk) begin
        if (rst) slot_q <= '0;
        else     slot_q <= slot_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        ramp_d  = ramp_q;
`ifdef BW_CLK_SEQ_STAGGER_EN
        slot_d  = slot_q;
`endif
        unique case (state_q)
            S_RST_HOLD: begin
                // cnt_q also counts the first post-reset edge, hence HOLD_N
                if (cnt_q == HOLD_N) begin
                    state_d = S_RAMP;
                    cnt_d   = '0;
`ifdef BW_CLK_SEQ_STAGGER_EN
                    slot_d  = '0;
                    ramp_d  = NUM_CLUSTERS'(1);
`else
                    ramp_d  = '1;
`endif
                end
            end
            S_RAMP: begin
                if (cnt_q == STAG_M1) begin
                    cnt_d = '0;
`ifdef BW_CLK_SEQ_STAGGER_EN
                    if (slot_q == LAST) begin
                        state_d = S_SETTLE;
                    end else begin
                        slot_d = slot_q + SW'(1);
                        ramp_d = ramp_q | (NUM_CLUSTERS'(1) << (slot_q + SW'(1)));
                    end
`else
                    state_d = S_SETTLE;
`endif
                end
            end
            S_SETTLE: begin
                if (cnt_q == HOLD_M1) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (pwr_rst_req)  state_d = S_SETTLE;
                else if (dbg_req) state_d = S_DBG;
            end
            S_DBG: begin
                if (pwr_rst_req) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == DBG_M1) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_RST_HOLD;
                cnt_d   = '0;
                ramp_d  = '0;
            end
        endcase
    end

    always_ff @(posedge gclk) begin
        if (rst) begin
            state_q      <= S_RST_HOLD;
            cnt_q        <= '0;
            ramp_q       <= '0;
            cluster_cken <= '0;
            grst_l       <= 1'b0;
            gdbginit_l   <= 1'b0;
            seq_busy     <= 1'b1;
            seq_done     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ramp_q       <= ramp_d;
            cluster_cken <= ramp_d & ~cken_mask;
            grst_l       <= (state_d == S_RUN) || (state_d == S_DBG);
            gdbginit_l   <= (state_d == S_RUN);
            seq_busy     <= (state_d != S_RUN);
            seq_done     <= (state_d == S_RUN) && (state_q != S_RUN);
        end
    end

endmodule

// File: doc/bw_clk_cken_seq.md
# bw_clk_cken_seq

Cluster clock-enable and reset sequencer in the clock control unit. It drives the `cluster_cken`, `grst_l` and `gdbginit_l` inputs of every cluster clock header (`bw_clk_cclk_hdr_*`), which in turn produce `rclk`, `cluster_grst_l` and `dbginit_l` for the cluster. On power-up it holds global reset, ramps cluster clock enables one cluster at a time to limit di/dt, lets reset propagate with clocks running, then releases reset. In RUN it services warm-reset and debug-init requests.

## Interface
- `NUM_CLUSTERS`, 4, number of cluster headers driven (≥1)
- `RST_HOLD_CYC`, 16, cycles of reset hold before the ramp and again after it (≥1)
- `STAGGER_CYC`, 4, cycles between successive cluster enables (≥1)
- `DBG_HOLD_CYC`, 8, cycles `gdbginit_l` is held low for a debug init (≥1)

- `gclk` in 1: global clock; the only clock
- `rst` in 1: synchronous, active-high reset
- `pwr_rst_req` in 1: warm reset request, sampled every cycle
- `dbg_req` in 1: debug init request, sampled every cycle
- `cken_mask` in NUM_CLUSTERS: 1 = cluster parked; its enable is forced to 0
- `cluster_cken` out NUM_CLUSTERS: per-cluster clock enable to the headers
- `grst_l` out 1: global reset to the headers, active low
- `gdbginit_l` out 1: global debug init to the headers, active low
- `seq_busy` out 1: 1 in every state except RUN
- `seq_done` out 1: one-cycle pulse on entry to RUN

## Operation
- All outputs are registered. Reset values while `rst`=1: `cluster_cken`=0, `grst_l`=0, `gdbginit_l`=0, `seq_busy`=1, `seq_done`=0. The state is RST_HOLD with the counter cleared.
- RST_HOLD: all enables 0, both resets low. Lasts RST_HOLD_CYC cycles, then goes to RAMP.
- RAMP: on slot i (i = 0..NUM_CLUSTERS-1), enable bit i is set and stays set; slots are STAGGER_CYC cycles apart.
  - A masked cluster still consumes its slot, so ramp timing is fixed.
  - After the last slot has run for STAGGER_CYC cycles, go to SETTLE.
- SETTLE: enables held, both resets low, for RST_HOLD_CYC cycles. Then go to RUN.
- RUN: `grst_l`=1, `gdbginit_l`=1, `seq_busy`=0. `seq_done` pulses in the first RUN cycle.
  - `pwr_rst_req`=1 goes to SETTLE; both resets drop, enables are untouched.
  - `dbg_req`=1 goes to DBG.
  - If both are 1 in the same cycle, `pwr_rst_req` wins.
- DBG: `gdbginit_l`=0, `grst_l`=1, for DBG_HOLD_CYC cycles, then back to RUN (with a `seq_done` pulse).
  - `pwr_rst_req`=1 during DBG aborts to SETTLE with a fresh counter.
- Requests in RST_HOLD, RAMP and SETTLE are ignored; they are not queued.
- `cluster_cken` = ramped_enables & ~`cken_mask`. Mask changes reach the output one cycle later in every state.
- `rst`=1 in any state returns the block to reset values on the next edge. The full sequence then restarts from RST_HOLD.
- Counter width is $clog2 of the largest of the three cycle parameters, plus 1. No wrap-around occurs inside a state.

## Timing
- Cycle 0 is the first edge at which `rst`=0 is sampled. Defaults used for the numbers below.
- `cluster_cken[i]` rises at cycle RST_HOLD_CYC + i·STAGGER_CYC: 16, 20, 24, 28.
- SETTLE starts at RST_HOLD_CYC + NUM_CLUSTERS·STAGGER_CYC = 32.
- `grst_l`, `gdbginit_l`, `seq_done` rise and `seq_busy` falls at cycle 2·RST_HOLD_CYC + NUM_CLUSTERS·STAGGER_CYC = 48.
- Warm reset with `pwr_rst_req` sampled at cycle t in RUN:
  - resets low from t+1 through t+RST_HOLD_CYC
  - resets high and `seq_done` at t+1+RST_HOLD_CYC
- Debug init with `dbg_req` sampled at cycle t in RUN:
  - `gdbginit_l` low from t+1 through t+DBG_HOLD_CYC
  - high at t+1+DBG_HOLD_CYC, with `seq_done`

## Configuration
- `BW_CLK_SEQ_STAGGER_EN` defined: staggered ramp as described above.
- `BW_CLK_SEQ_STAGGER_EN` undefined:
  - RAMP sets all enable bits in its first cycle and lasts STAGGER_CYC cycles total.
  - All unmasked `cluster_cken` bits rise at cycle 16; `grst_l` rises at cycle 2·16+4 = 36.
  - All other behaviour is unchanged.

## Test plan
- Power-up, defaults, mask=0, stagger on → `cken` bits rise at 16/20/24/28; `grst_l`, `gdbginit_l`, `seq_done` at 48; `seq_done` is exactly one cycle.
- Power-up with stagger macro undefined → all four `cken` bits rise at 16; `grst_l` at 36.
- `cken_mask`=4'b0100 at power-up, then cleared at cycle 60 → bit 2 stays 0 through the ramp (others at 16/20/28); bit 2 rises at 61; `grst_l` still at 48.
- In RUN, `dbg_req` pulse at cycle 100 → `gdbginit_l` low 101..108; `grst_l` stays 1; `seq_done` at 109. `pwr_rst_req`+`dbg_req` together at 200 → both resets low 201..216, high at 217.
- `dbg_req` at 300, then `pwr_rst_req` at 303 → `gdbginit_l` low 301..319; `grst_l` low 304..319; both high at 320.
- `rst` pulsed at cycle 22 (mid-ramp) → all outputs return to reset values at the next edge; the sequence restarts, with `cken[0]` rising 16 cycles after `rst` falls. A `pwr_rst_req` during RAMP has no effect.
